rtype_seq_ctrl: RTL

- Multi-cycle sequencer for the R-type datapath.
- Fetches one 32-bit instruction per pass over a req/ack instruction port.
- Decodes OP/func into the 3-bit ALU operation code and register addresses.
- Drives ALU result latching and the register-file write enable over FETCH/DECODE/EXEC/WB states, then advances the PC.
- Sits between instruction memory, register file and ALU; replaces free-running combinational decode with a clocked controller.

---
 rtl/rtype_seq_ctrl_if.sv | 26 ++
 rtl/rtype_seq_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/rtype_seq_ctrl_if.sv
// Instruction-fetch port of the R-type sequencer.
//   I_REQ  : fetch request (controller -> memory)
//   I_ADDR : fetch address, the current PC (controller -> memory)
//   I_ACK  : instruction valid this cycle (memory -> controller)
//   I_DATA : instruction word, sampled when I_REQ & I_ACK (memory -> controller)
// The master modport is the controller side; the slave modport is the memory side.
interface rtype_seq_ctrl_if;
    logic        I_REQ;
    logic [31:0] I_ADDR;
    logic        I_ACK;
    logic [31:0] I_DATA;

    modport master (
        output I_REQ,
        output I_ADDR,
        input  I_ACK,
        input  I_DATA
    );

    modport slave (
        input  I_REQ,
        input  I_ADDR,
        output I_ACK,
        output I_DATA
    );
endinterface

// File: rtl/rtype_seq_ctrl.sv
// Multi-cycle sequencer for the R-type datapath.
// Each pass runs FETCH -> DECODE -> EXEC -> WB, then advances the PC by 4.
// Ports:
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   run          : level enable; leaves IDLE and continues while high
//   imem         : instruction fetch port (req/ack, address, data)
//   R_ADDR_A/B   : register-file read addresses, IR[25:21] / IR[20:16]
//   W_ADDR       : register-file write address, IR[15:11]
//   ALU_OP       : 3-bit ALU operation, updated in DECODE for legal instructions
//   ALU_LATCH    : one-cycle strobe in EXEC for legal instructions
//   WE           : one-cycle write strobe in WB (legal and W_ADDR != 0)
//   ILLEGAL      : one-cycle pulse in WB for unsupported instructions
//   FETCH_FAULT  : one-cycle pulse after FETCH_TIMEOUT cycles without I_ACK
//   BUSY         : high in every state except IDLE
//   RETIRED      : count of completed instructions, wraps at 2^CNT_W
module rtype_seq_ctrl #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int unsigned FETCH_TIMEOUT = 16,
    parameter int unsigned CNT_W         = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    rtype_seq_ctrl_if.master     imem,
    output logic [4:0]           R_ADDR_A,
    output logic [4:0]           R_ADDR_B,
    output logic [4:0]           W_ADDR,
    output logic [2:0]           ALU_OP,
    output logic                 ALU_LATCH,
    output logic                 WE,
    output logic                 ILLEGAL,
    output logic                 FETCH_FAULT,
    output logic                 BUSY,
    output logic [CNT_W-1:0]     RETIRED
);

    typedef enum logic [2:0] {StIdle, StFetch, StDecode, StExec, StWb} state_e;

    // Counter value seen in the last FETCH cycle that may still be acknowledged.
    localparam logic [7:0] TimeoutLast = 8'(FETCH_TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        ir_q, ir_d;
    logic [2:0]         alu_op_q, alu_op_d;
    logic               legal_q, legal_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               i_req_q, i_req_d;
    logic               alu_latch_q, alu_latch_d;
    logic               we_q, we_d;
    logic               illegal_q, illegal_d;
    logic               fault_q, fault_d;
    logic               busy_q, busy_d;

    logic               dec_legal;
    logic [2:0]         dec_op;

    // Shift-amount field is not used by any supported operation.
    logic unused_shamt;
    assign unused_shamt = ^ir_q[10:6];

    // Opcode/func decode of the held instruction register.
    always_comb begin
        dec_legal = 1'b0;
        dec_op    = 3'b000;
        if (ir_q[31:26] == 6'b000000) begin
            dec_legal = 1'b1;
            unique case (ir_q[5:0])
                6'b100000: dec_op = 3'b100;
                6'b100010: dec_op = 3'b101;
                6'b100100: dec_op = 3'b000;
                6'b100101: dec_op = 3'b001;
                6'b100110: dec_op = 3'b010;
                6'b100111: dec_op = 3'b011;
                6'b101011: dec_op = 3'b110;
                6'b000100: dec_op = 3'b111;
                default:   dec_legal = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        alu_op_d    = alu_op_q;
        legal_d     = legal_q;
        cnt_d       = cnt_q;
        retired_d   = retired_q;
        alu_latch_d = 1'b0;
        we_d        = 1'b0;
        illegal_d   = 1'b0;
        fault_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (run) state_d = StFetch;
            end
            StFetch: begin
                if (imem.I_ACK) begin
                    ir_d    = imem.I_DATA;
                    cnt_d   = 8'd0;
                    state_d = StDecode;
                end else if (cnt_q == TimeoutLast) begin
                    cnt_d   = 8'd0;
                    fault_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StDecode: begin
                legal_d     = dec_legal;
                // Illegal instructions leave the last ALU operation in place.
                if (dec_legal) alu_op_d = dec_op;
                alu_latch_d = dec_legal;
                state_d     = StExec;
            end
            StExec: begin
                // Writes to $0 are dropped without flagging anything.
                we_d      = legal_q && (ir_q[15:11] != 5'd0);
                illegal_d = !legal_q;
                state_d   = StWb;
            end
            StWb: begin
                pc_d      = pc_q + 32'd4;
                retired_d = retired_q + CNT_W'(1);
                state_d   = run ? StFetch : StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Strobes are decodes of the state being entered, so they line up with it.
        i_req_d = (state_d == StFetch);
        busy_d  = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            pc_q        <= RESET_PC;
            ir_q        <= 32'd0;
            alu_op_q    <= 3'b000;
            legal_q     <= 1'b0;
            cnt_q       <= 8'd0;
            retired_q   <= '0;
            i_req_q     <= 1'b0;
            alu_latch_q <= 1'b0;
            we_q        <= 1'b0;
            illegal_q   <= 1'b0;
            fault_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            alu_op_q    <= alu_op_d;
            legal_q     <= legal_d;
            cnt_q       <= cnt_d;
            retired_q   <= retired_d;
            i_req_q     <= i_req_d;
            alu_latch_q <= alu_latch_d;
            we_q        <= we_d;
            illegal_q   <= illegal_d;
            fault_q     <= fault_d;
            busy_q      <= busy_d;
        end
    end

    assign imem.I_REQ  = i_req_q;
    assign imem.I_ADDR = pc_q;
    assign R_ADDR_A    = ir_q[25:21];
    assign R_ADDR_B    = ir_q[20:16];
    assign W_ADDR      = ir_q[15:11];
    assign ALU_OP      = alu_op_q;
    assign ALU_LATCH   = alu_latch_q;
    assign WE          = we_q;
    assign ILLEGAL     = illegal_q;
    assign FETCH_FAULT = fault_q;
    assign BUSY        = busy_q;
    assign RETIRED     = retired_q;

endmodule
